fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Fetch sequencer for the simple processor. It drives the program counter into the 16-entry, 12-bit combinational instruction memory and latches the returned word into an instruction register. It then offers that word to the execute stage with a valid/ready handshake. It supports run and single-step modes, branch redirect from execute, PC wrap-around, and halt on a NOP fetch.

## Interface
Parameters:
- PC_W, 4, program counter width (memory depth 2**PC_W)
- INSTR_W, 12, instruction width
- HALT_ON_NOP, 1, 1 = fetching the all-zero word halts; 0 = NOP issued like any instruction
- CNT_W, 8, retired-instruction counter width

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse; begins or resumes fetching
- step_mode  in  1  1 = pause in IDLE after each issued instruction
- pc  out  PC_W  address to instruction memory
- instr  in  INSTR_W  combinational read data for `pc`
- ir  out  INSTR_W  latched instruction to execute
- ir_valid  out  1  `ir` holds an unissued instruction
- ir_ready  in  1  execute accepts `ir` this cycle
- redirect_valid  in  1  branch taken; sampled only on handshake cycle
- redirect_pc  in  PC_W  branch target
- running  out  1  state is FETCH or ISSUE
- halted  out  1  state is HALT
- retired  out  CNT_W  count of issued instructions, saturating

## Operation
States: IDLE, FETCH, ISSUE, HALT.
- IDLE: `start` -> FETCH, resuming at the current `pc`.
- FETCH, one cycle: `instr` is read at `pc`.
  - If HALT_ON_NOP and instr == 0: go to HALT. `ir` is not loaded, `pc` does not advance, `retired` does not change.
  - Otherwise: ir <= instr, ir_valid <= 1, go to ISSUE.
- ISSUE: holds `ir` and `ir_valid` stable until ir_valid && ir_ready. On that handshake:
  - ir_valid <= 0.
  - pc <= redirect_valid ? redirect_pc : pc + 1, modulo 2**PC_W, so 15 wraps to 0.
  - retired <= retired + 1, saturating at 2**CNT_W - 1.
  - Next state is IDLE if step_mode, else FETCH.
- HALT: `pc` holds the NOP address.
  - `start` restarts the program: pc <= 0, retired <= 0, go to FETCH.
- `start` is ignored in FETCH and ISSUE.
- `redirect_valid` is ignored outside the handshake cycle.
- `step_mode` is sampled only on the handshake cycle.
- `running` and `halted` are decoded from the state register.

## Timing
- Reset values, on a clock edge with rst_n = 0: state IDLE, pc = 0, ir = 0, ir_valid = 0, retired = 0, running = 0, halted = 0.
- Reset mid-operation: `ir_valid` drops at that edge. No handshake completes that cycle, even if ir_ready = 1.
- Start to first valid instruction: `start` high at edge N moves the state to FETCH after N. `ir_valid` is high after edge N+1.
- Throughput: one instruction per 2 cycles with ir_ready held high (FETCH + ISSUE). Each cycle ir_ready stays low adds one cycle.
- A redirect target is fetched in the cycle immediately after the handshake.
- Redirect to the current `pc` (self-loop) is legal. That address is re-fetched.
- `retired` updates on the handshake edge.
- `pc` changes only on:
  - the handshake edge
  - the HALT restart edge
  - reset

## Structure
- Shared package/include `proc_pkg` holds:
  - PC_W, INSTR_W
  - NOP_INSTR = 0
  - state encodings: IDLE = 0, FETCH = 1, ISSUE = 2, HALT = 3
- Shared with the instruction memory and the execute stage.
- Single module: FSM, PC register, IR register, counter. No sub-module.
- `pc` is a registered output; no combinational path from any input to `pc`.

## Test plan
Memory model programs used below: 0x120, 0x211, 0x320, 0x000, ...
- Run mode, ir_ready tied 1, start pulse:
  - `ir` issues 0x120, 0x211, 0x320 at pc 0, 1, 2, one every 2 cycles.
  - Fetch at pc 3 goes to HALT with pc = 3, retired = 3, halted = 1.
- Backpressure, ir_ready low for 5 cycles on the first issue:
  - ir = 0x120 and ir_valid = 1 stay stable throughout; pc stays 0.
  - Handshake completes on the cycle ir_ready rises.
- Step mode:
  - Each start pulse yields exactly one issue, then running = 0 in IDLE.
  - After three pulses: pc = 3, retired = 3.
  - A fourth pulse halts.
- Wrap and redirect, memory all 0x001 with HALT_ON_NOP = 1:
  - pc sequence 0..15 then 0. `retired` saturates at 255, never wraps.
  - redirect_valid with redirect_pc = 9 on the pc = 4 handshake: next fetch at 9.
  - redirect_valid asserted outside a handshake has no effect.
- Reset and restart:
  - rst_n low during ISSUE at pc = 2: the next edge gives ir_valid = 0, pc = 0, state IDLE.
  - From HALT, a start pulse gives pc = 0, retired = 0, and refetches 0x120.
- start asserted during FETCH or ISSUE: no state or pc perturbation.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor: fetch, instruction memory and execute.
package proc_pkg;

   localparam int unsigned PC_W    = 4;
   localparam int unsigned INSTR_W = 12;

   localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives pc into instruction memory, latches the word into ir
// and offers it to execute with valid/ready; run/step modes, redirect, halt on NOP.
module fetch_sequencer #(
   parameter int unsigned PC_W        = proc_pkg::PC_W,
   parameter int unsigned INSTR_W     = proc_pkg::INSTR_W,
   parameter bit          HALT_ON_NOP = 1'b1,
   parameter int unsigned CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               step_mode,
   output logic [PC_W-1:0]    pc,
   input  logic [INSTR_W-1:0] instr,
   output logic [INSTR_W-1:0] ir,
   output logic               ir_valid,
   input  logic               ir_ready,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               running,
   output logic               halted,
   output logic [CNT_W-1:0]   retired
);
   import proc_pkg::*;

   state_e               r_state;
   state_e               w_state_nxt;
   logic [PC_W-1:0]      r_pc;
   logic [INSTR_W-1:0]   r_ir;
   logic                 r_ir_valid;
   logic [CNT_W-1:0]     r_retired;
   logic                 w_load_ir;
   logic                 w_handshake;
   logic                 w_restart;
   logic                 w_is_nop;

   assign w_is_nop = (instr == INSTR_W'(NOP_INSTR));

   // Next-state and datapath enables
   always_comb begin
      w_state_nxt = r_state;
      w_load_ir   = 1'b0;
      w_handshake = 1'b0;
      w_restart   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (HALT_ON_NOP && w_is_nop) begin
               w_state_nxt = S_HALT;
            end else begin
               w_load_ir   = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (r_ir_valid && ir_ready) begin
               w_handshake = 1'b1;
               w_state_nxt = step_mode ? S_IDLE : S_FETCH;
            end
         end
         S_HALT: begin
            if (start) begin
               w_restart   = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // PC, IR and retired counter; pc moves only on handshake, restart or reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc       <= '0;
         r_ir       <= '0;
         r_ir_valid <= 1'b0;
         r_retired  <= '0;
      end else begin
         if (w_load_ir) begin
            r_ir       <= instr;
            r_ir_valid <= 1'b1;
         end
         if (w_handshake) begin
            r_ir_valid <= 1'b0;
            r_pc       <= redirect_valid ? redirect_pc : r_pc + PC_W'(1);
            if (r_retired != {CNT_W{1'b1}}) r_retired <= r_retired + CNT_W'(1);
         end
         if (w_restart) begin
            r_pc      <= '0;
            r_retired <= '0;
         end
      end
   end

   assign pc       = r_pc;
   assign ir       = r_ir;
   assign ir_valid = r_ir_valid;
   assign retired  = r_retired;
   assign running  = (r_state == S_FETCH) || (r_state == S_ISSUE);
   assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a 16-entry memory model.
module tb_fetch_sequencer;

   localparam int unsigned PC_W    = 4;
   localparam int unsigned INSTR_W = 12;
   localparam int unsigned CNT_W   = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               step_mode;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] instr;
   logic [INSTR_W-1:0] ir;
   logic               ir_valid;
   logic               ir_ready;
   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;
   logic               running;
   logic               halted;
   logic [CNT_W-1:0]   retired;

   logic [INSTR_W-1:0] mem [16];
   logic [INSTR_W-1:0] prog [3];

   int unsigned chk_cnt = 0;
   int unsigned err_cnt = 0;

   always #5 clk = ~clk;

   assign instr = mem[pc];

   fetch_sequencer #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .HALT_ON_NOP(1'b1), .CNT_W(CNT_W)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode),
      .pc(pc), .instr(instr), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .running(running), .halted(halted), .retired(retired)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_program();
      for (int i = 0; i < 16; i++) mem[i] = '0;
      for (int i = 0; i < 3; i++) mem[i] = prog[i];
   endtask

   initial begin
      int unsigned exp_pc;
      int unsigned exp_ret;
      prog[0] = 12'h120; prog[1] = 12'h211; prog[2] = 12'h320;
      load_program();
      rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; ir_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0;
      tick(); tick();
      check("rst_pc",       32'(pc), 32'd0);
      check("rst_ir",       32'(ir), 32'd0);
      check("rst_ir_valid", 32'(ir_valid), 32'd0);
      check("rst_retired",  32'(retired), 32'd0);
      check("rst_running",  32'(running), 32'd0);
      check("rst_halted",   32'(halted), 32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_stays", 32'(running), 32'd0);

      // Run mode, ready tied high
      start = 1'b1; tick(); start = 1'b0;
      check("run_fetch_running", 32'(running), 32'd1);
      check("run_fetch_novalid", 32'(ir_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("run_ir",       32'(ir), 32'(prog[i]));
         check("run_ir_valid", 32'(ir_valid), 32'd1);
         check("run_pc_issue", 32'(pc), 32'(i));
         tick();
         check("run_pc_next",  32'(pc), 32'(i + 1));
         check("run_retired",  32'(retired), 32'(i + 1));
         check("run_hs_valid", 32'(ir_valid), 32'd0);
      end
      tick();
      check("halt_halted",  32'(halted), 32'd1);
      check("halt_running", 32'(running), 32'd0);
      check("halt_pc",      32'(pc), 32'd3);
      check("halt_retired", 32'(retired), 32'd3);
      check("halt_ir_kept", 32'(ir), 32'h320);
      tick();
      check("halt_hold_pc", 32'(pc), 32'd3);

      // Restart from HALT with backpressure on the first issue
      ir_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      check("restart_pc",      32'(pc), 32'd0);
      check("restart_retired", 32'(retired), 32'd0);
      check("restart_running", 32'(running), 32'd1);
      tick();
      check("restart_ir", 32'(ir), 32'h120);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         tick();
         check("bp_ir",       32'(ir), 32'h120);
         check("bp_ir_valid", 32'(ir_valid), 32'd1);
         check("bp_pc",       32'(pc), 32'd0);
         check("bp_retired",  32'(retired), 32'd0);
         check("bp_running",  32'(running), 32'd1);
      end
      start = 1'b0;
      ir_ready = 1'b1;
      tick();
      check("bp_hs_pc",    32'(pc), 32'd1);
      check("bp_hs_valid", 32'(ir_valid), 32'd0);
      check("bp_hs_ret",   32'(retired), 32'd1);
      start = 1'b1; tick(); start = 1'b0;
      check("start_in_fetch_ir", 32'(ir), 32'h211);
      check("start_in_fetch_pc", 32'(pc), 32'd1);
      tick();
      check("pc2_hs", 32'(pc), 32'd2);
      tick();
      check("pc2_issue_ir", 32'(ir), 32'h320);

      // Reset during ISSUE with ready high: no handshake completes
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("midrst_valid",   32'(ir_valid), 32'd0);
      check("midrst_pc",      32'(pc), 32'd0);
      check("midrst_running", 32'(running), 32'd0);
      check("midrst_halted",  32'(halted), 32'd0);
      check("midrst_retired", 32'(retired), 32'd0);

      // Step mode: one issue per start pulse
      step_mode = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start = 1'b1; tick(); start = 1'b0;
         tick();
         check("step_ir", 32'(ir), 32'(prog[k]));
         tick();
         check("step_idle",    32'(running), 32'd0);
         check("step_pc",      32'(pc), 32'(k + 1));
         check("step_retired", 32'(retired), 32'(k + 1));
         tick();
         check("step_stays_idle", 32'(running), 32'd0);
      end
      start = 1'b1; tick(); start = 1'b0;
      tick();
      check("step_halt",    32'(halted), 32'd1);
      check("step_halt_pc", 32'(pc), 32'd3);

      // Wrap and saturation with memory full of 0x001
      step_mode = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 12'h001;
      start = 1'b1; tick(); start = 1'b0;
      exp_ret = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         check("wrap_pc_issue", 32'(pc), 32'(i % 16));
         tick();
         if (exp_ret < 255) exp_ret++;
         check("wrap_pc_next", 32'(pc), 32'((i + 1) % 16));
         check("wrap_retired", 32'(retired), 32'(exp_ret));
      end

      // Redirect: only the pc=4 handshake takes it
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      exp_pc = 0;
      for (int j = 0; j < 7; j++) begin
         redirect_valid = 1'b1; redirect_pc = 4'd9;
         tick();
         check("redir_issue_pc", 32'(pc), 32'(exp_pc));
         redirect_valid = (exp_pc == 4);
         tick();
         exp_pc = (exp_pc == 4) ? 9 : exp_pc + 1;
         check("redir_next_pc", 32'(pc), 32'(exp_pc));
      end
      redirect_valid = 1'b0;
      tick();
      redirect_valid = 1'b1; redirect_pc = 4'(exp_pc);
      tick();
      redirect_valid = 1'b0;
      check("self_loop_pc", 32'(pc), 32'(exp_pc));
      tick();
      check("self_loop_refetch", 32'(ir_valid), 32'd1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
